softmax_in_stage: RTL and testbench

Input framing stage placed directly upstream of the pipelined softmax core. It accepts a serial stream of IEEE-754 single-precision logits, one word per handshake, and buffers one full vector of TOTAL_WORDS words. While buffering it tracks the vector maximum. It then emits the vector as TOTAL_WORDS/PARALLEL_FACTOR wide beats of PARALLEL_FACTOR lanes, and presents the vector maximum alongside every beat so the core can do max-subtraction.

---
 rtl/softmax_in_stage.sv | 158 +++++++++++++++
 tb/tb_softmax_in_stage.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_in_stage.sv
// softmax_in_stage
// ----------------
// Input framing stage for the pipelined softmax core. Collects one vector of
// TOTAL_WORDS fp32 logits from a serial valid/ready stream, tracks the vector
// maximum while filling, then replays the vector as TOTAL_WORDS/PARALLEL_FACTOR
// wide beats with the maximum presented alongside every beat.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   s_data     fp32 input word
//   s_valid    s_data valid
//   s_last     final word of the vector
//   s_ready    stage accepts a word (FILL state)
//   data_out   output beat, lane i at [32i+31:32i]
//   max_out    fp32 maximum of the vector being drained
//   out_valid  beat valid (DRAIN state)
//   out_ready  downstream accepts the beat
//   out_first  beat 0 of the vector
//   out_last   final beat of the vector
//   frame_err  one-cycle pulse after a framing violation
module softmax_in_stage #(
    parameter int TOTAL_WORDS     = 16,
    parameter int PARALLEL_FACTOR = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   s_data,
    input  logic                          s_valid,
    input  logic                          s_last,
    output logic                          s_ready,
    output logic [32*PARALLEL_FACTOR-1:0] data_out,
    output logic [31:0]                   max_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_first,
    output logic                          out_last,
    output logic                          frame_err
);

    localparam int NB = TOTAL_WORDS / PARALLEL_FACTOR;
    localparam int WW = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    localparam logic [WW-1:0] WCNT_LAST = WW'(TOTAL_WORDS - 1);
    localparam logic [BW-1:0] BCNT_LAST = BW'(NB - 1);

    logic [0:0]    state_q, state_d;
    logic          ready_q, ready_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [31:0]   max_q, max_d;
    logic          ferr_q, ferr_d;

    logic [31:0]   buf_q [TOTAL_WORDS];

    logic accept;
    logic drain_fire;

    // Order-preserving integer key for fp32: negatives are bit-inverted so
    // larger magnitude sorts lower, positives get the top bit set so they sort
    // above every negative. NaNs fall out at the extremes naturally.
    function automatic logic [31:0] fp_key(input logic [31:0] b);
        return b[31] ? ~b : (b | 32'h8000_0000);
    endfunction

    // ready_q is a separate register (rather than decoding state_q) so that
    // s_ready is low throughout reset and rises on the first edge after it.
    assign accept     = s_valid && ready_q;
    assign drain_fire = (state_q == ST_DRAIN) && out_ready;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        max_d   = max_q;
        ferr_d  = 1'b0;

        if (accept) begin
            if (wcnt_q == '0) begin
                max_d = s_data;
            end else if (fp_key(s_data) > fp_key(max_q)) begin
                max_d = s_data;
            end

            if (wcnt_q == WCNT_LAST) begin
                wcnt_d = '0;
                if (s_last) begin
                    state_d = ST_DRAIN;
                    bcnt_d  = '0;
                end else begin
                    ferr_d = 1'b1;          // missing last: drop the vector
                end
            end else if (s_last) begin
                ferr_d = 1'b1;              // early last: drop the partial vector
                wcnt_d = '0;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end

        if (drain_fire) begin
            if (bcnt_q == BCNT_LAST) begin
                state_d = ST_FILL;
                wcnt_d  = '0;
                bcnt_d  = '0;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end

        ready_d = (state_d == ST_FILL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FILL;
            ready_q <= 1'b0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            max_q   <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            max_q   <= max_d;
            ferr_q  <= ferr_d;
        end
    end

    // Vector storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[wcnt_q] <= s_data;
        end
    end

    // Lane gi of the current beat is slot bcnt*PARALLEL_FACTOR + gi. Lanes are
    // forced to zero outside DRAIN so data_out reads 0 in reset and FILL.
    for (genvar gi = 0; gi < PARALLEL_FACTOR; gi++) begin : g_lane
        logic [31:0] lane_word;
        assign lane_word = buf_q[WW'(int'(bcnt_q) * PARALLEL_FACTOR + gi)];
        assign data_out[32*gi +: 32] = (state_q == ST_DRAIN) ? lane_word : 32'h0;
    end

    assign s_ready   = ready_q;
    assign out_valid = (state_q == ST_DRAIN);
    assign max_out   = max_q;
    assign out_first = out_valid && (bcnt_q == '0);
    assign out_last  = out_valid && (bcnt_q == BCNT_LAST);
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_softmax_in_stage.sv
module tb_softmax_in_stage;

    logic         clk = 1'b0;
    logic         rst;

    // default instance (16 words, 8 lanes)
    logic [31:0]  s_data;
    logic         s_valid, s_last, s_ready;
    logic [255:0] data_out;
    logic [31:0]  max_out;
    logic         out_valid, out_ready, out_first, out_last, frame_err;

    // TOTAL_WORDS=8 instance
    logic [31:0]  s8_data;
    logic         s8_valid, s8_last, s8_ready;
    logic [255:0] d8_out;
    logic [31:0]  m8_out;
    logic         v8_out, r8_out, f8_first, l8_last, e8_err;

    // TOTAL_WORDS=32 instance
    logic [31:0]  s32_data;
    logic         s32_valid, s32_last, s32_ready;
    logic [255:0] d32_out;
    logic [31:0]  m32_out;
    logic         v32_out, r32_out, f32_first, l32_last, e32_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] vec [0:31];
    logic [31:0] ramp [0:15] = '{
        32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
        32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
        32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
        32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

    localparam logic [255:0] EXP_B0 =
        256'h41000000_40E00000_40C00000_40A00000_40800000_40400000_40000000_3F800000;
    localparam logic [255:0] EXP_B1 =
        256'h41800000_41700000_41600000_41500000_41400000_41300000_41200000_41100000;

    always #5 clk = ~clk;

    softmax_in_stage #(.TOTAL_WORDS(16), .PARALLEL_FACTOR(8)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .data_out(data_out), .max_out(max_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
        .frame_err(frame_err));

    softmax_in_stage #(.TOTAL_WORDS(8), .PARALLEL_FACTOR(8)) dut8 (
        .clk(clk), .rst(rst), .s_data(s8_data), .s_valid(s8_valid), .s_last(s8_last),
        .s_ready(s8_ready), .data_out(d8_out), .max_out(m8_out), .out_valid(v8_out),
        .out_ready(r8_out), .out_first(f8_first), .out_last(l8_last),
        .frame_err(e8_err));

    softmax_in_stage #(.TOTAL_WORDS(32), .PARALLEL_FACTOR(8)) dut32 (
        .clk(clk), .rst(rst), .s_data(s32_data), .s_valid(s32_valid), .s_last(s32_last),
        .s_ready(s32_ready), .data_out(d32_out), .max_out(m32_out), .out_valid(v32_out),
        .out_ready(r32_out), .out_first(f32_first), .out_last(l32_last),
        .frame_err(e32_err));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stream n words of vec[]; s_last is raised on index last_at (-1: never).
    // Returns one tick after the edge that accepted the final word.
    task automatic send_words(input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            s_valid = 1'b1;
            s_data  = vec[i];
            s_last  = (i == last_at);
            while (!s_ready && t < 50) begin
                step();
                t++;
            end
            if (t >= 50) begin
                n_checks++;
                $display("FAIL send_timeout word=%0d s_ready=%b required=1", i, s_ready);
            end
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic take_beat();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) vec[i] = ramp[i];
    endtask

    task automatic test_reset();
        n_checks++;
        if ({s_ready, out_valid, out_first, out_last, frame_err} !== 5'b0) begin
            $display("FAIL reset_flags got=%b required=00000",
                     {s_ready, out_valid, out_first, out_last, frame_err});
        end else n_pass++;
        n_checks++;
        if (data_out !== 256'h0 || max_out !== 32'h0) begin
            $display("FAIL reset_data data_out=%h max_out=%h required=0", data_out, max_out);
        end else n_pass++;
        rst = 1'b1;
        step();
        n_checks++;
        if (s_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL reset_release s_ready=%b out_valid=%b required 1/0", s_ready, out_valid);
        end else n_pass++;
        $display("reset released: s_ready=%b", s_ready);
    endtask

    task automatic test_basic();
        load_ramp();
        send_words(16, 15);
        n_checks++;
        if ({out_valid, out_first, out_last, s_ready} !== 4'b1100) begin
            $display("FAIL basic_b0_flags got=%b required=1100",
                     {out_valid, out_first, out_last, s_ready});
        end else n_pass++;
        n_checks++;
        if (data_out !== EXP_B0 || max_out !== 32'h41800000) begin
            $display("FAIL basic_b0_data data=%h max=%h required=%h/41800000",
                     data_out, max_out, EXP_B0);
        end else n_pass++;
        $display("basic beat0 max=%h first=%b", max_out, out_first);
        take_beat();
        n_checks++;
        if ({out_valid, out_first, out_last} !== 3'b101) begin
            $display("FAIL basic_b1_flags got=%b required=101", {out_valid, out_first, out_last});
        end else n_pass++;
        n_checks++;
        if (data_out !== EXP_B1 || max_out !== 32'h41800000) begin
            $display("FAIL basic_b1_data data=%h max=%h required=%h/41800000",
                     data_out, max_out, EXP_B1);
        end else n_pass++;
        $display("basic beat1 max=%h last=%b", max_out, out_last);
        take_beat();
        n_checks++;
        if (s_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL basic_refill s_ready=%b out_valid=%b required 1/0", s_ready, out_valid);
        end else n_pass++;
    endtask

    task automatic test_signed_max();
        for (int i = 0; i < 16; i++) vec[i] = 32'hC0400000;
        vec[4] = 32'hBF000000;
        send_words(16, 15);
        n_checks++;
        if (max_out !== 32'hBF000000 || data_out[159:128] !== 32'hBF000000
            || data_out[31:0] !== 32'hC0400000) begin
            $display("FAIL signed_neg max=%h lane4=%h lane0=%h required BF000000/BF000000/C0400000",
                     max_out, data_out[159:128], data_out[31:0]);
        end else n_pass++;
        $display("signed vector max=%h", max_out);
        take_beat();
        take_beat();

        for (int i = 0; i < 16; i++) vec[i] = 32'h80000000;
        vec[8] = 32'h00000000;
        send_words(16, 15);
        n_checks++;
        if (max_out !== 32'h00000000) begin
            $display("FAIL signed_zero max=%h required=00000000", max_out);
        end else n_pass++;
        take_beat();
        n_checks++;
        if (data_out[31:0] !== 32'h0 || data_out[63:32] !== 32'h80000000 || max_out !== 32'h0) begin
            $display("FAIL signed_zero_b1 lane0=%h lane1=%h max=%h required 0/80000000/0",
                     data_out[31:0], data_out[63:32], max_out);
        end else n_pass++;
        $display("zero vector max=%h", max_out);
        take_beat();

        // +inf first, positive NaN later, negative NaN after that
        for (int i = 0; i < 16; i++) vec[i] = 32'h3F800000;
        vec[0]  = 32'h7F800000;
        vec[3]  = 32'h7FC00000;
        vec[10] = 32'hFFC00000;
        send_words(16, 15);
        n_checks++;
        if (max_out !== 32'h7FC00000) begin
            $display("FAIL nan_order max=%h required=7FC00000", max_out);
        end else n_pass++;
        $display("nan vector max=%h", max_out);
        take_beat();
        take_beat();
    endtask

    task automatic test_backpressure();
        logic bad;
        int   beats;
        logic [255:0] exp_beat;
        load_ramp();
        send_words(16, 15);
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (data_out !== EXP_B0 || max_out !== 32'h41800000 || s_ready !== 1'b0
                || out_valid !== 1'b1 || out_first !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            $display("FAIL stall_hold data=%h max=%h s_ready=%b required %h/41800000/0",
                     data_out, max_out, s_ready, EXP_B0);
        end else n_pass++;
        $display("stall 10 cycles held=%b", !bad);
        take_beat();
        take_beat();

        // random out_ready: beats must arrive in order, exactly two of them
        load_ramp();
        send_words(16, 15);
        beats = 0;
        bad   = 1'b0;
        for (int c = 0; c < 60; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (c > 40) out_ready = 1'b1;
            if (out_valid && out_ready) begin
                exp_beat = (beats == 0) ? EXP_B0 : EXP_B1;
                if (beats > 1 || data_out !== exp_beat) bad = 1'b1;
                beats++;
            end
            step();
        end
        out_ready = 1'b0;
        n_checks++;
        if (bad || beats !== 2) begin
            $display("FAIL random_ready beats=%0d order_bad=%b required 2/0", beats, bad);
        end else n_pass++;
        $display("random ready beats=%0d", beats);
    endtask

    task automatic test_framing();
        logic bad;
        load_ramp();
        send_words(7, 6);
        n_checks++;
        if (frame_err !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL early_last frame_err=%b out_valid=%b required 1/0", frame_err, out_valid);
        end else n_pass++;
        step();
        n_checks++;
        if (frame_err !== 1'b0 || s_ready !== 1'b1) begin
            $display("FAIL early_last_pulse frame_err=%b s_ready=%b required 0/1", frame_err, s_ready);
        end else n_pass++;
        $display("early last handled");

        send_words(16, 15);
        n_checks++;
        if (out_valid !== 1'b1 || out_first !== 1'b1 || data_out !== EXP_B0) begin
            $display("FAIL after_err_vec valid=%b first=%b data=%h required 1/1/%h",
                     out_valid, out_first, data_out, EXP_B0);
        end else n_pass++;
        take_beat();
        n_checks++;
        if (data_out !== EXP_B1 || out_last !== 1'b1) begin
            $display("FAIL after_err_b1 data=%h last=%b required %h/1", data_out, out_last, EXP_B1);
        end else n_pass++;
        take_beat();

        send_words(16, -1);
        n_checks++;
        if (frame_err !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL missing_last frame_err=%b out_valid=%b required 1/0", frame_err, out_valid);
        end else n_pass++;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (out_valid !== 1'b0 || frame_err !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            $display("FAIL missing_last_quiet out_valid=%b frame_err=%b required 0/0", out_valid, frame_err);
        end else n_pass++;
        $display("missing last handled");
    endtask

    task automatic test_reset_abort();
        load_ramp();
        send_words(16, 15);
        n_checks++;
        if (out_valid !== 1'b1) begin
            $display("FAIL abort_pre out_valid=%b required=1", out_valid);
        end else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || s_ready !== 1'b0 || data_out !== 256'h0) begin
            $display("FAIL abort_async out_valid=%b s_ready=%b data=%h required 0/0/0",
                     out_valid, s_ready, data_out);
        end else n_pass++;
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || s_ready !== 1'b1) begin
            $display("FAIL abort_release out_valid=%b s_ready=%b required 0/1", out_valid, s_ready);
        end else n_pass++;
        for (int i = 0; i < 16; i++) vec[i] = 32'hC0400000;
        vec[4] = 32'hBF000000;
        send_words(16, 15);
        n_checks++;
        if (out_first !== 1'b1 || data_out[31:0] !== 32'hC0400000 || max_out !== 32'hBF000000) begin
            $display("FAIL abort_next first=%b lane0=%h max=%h required 1/C0400000/BF000000",
                     out_first, data_out[31:0], max_out);
        end else n_pass++;
        $display("post-reset vector max=%h", max_out);
        take_beat();
        take_beat();
        n_checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL abort_done out_valid=%b required=0", out_valid);
        end else n_pass++;
    endtask

    task automatic test_param8();
        for (int i = 0; i < 8; i++) begin
            int t = 0;
            s8_valid = 1'b1;
            s8_data  = ramp[i];
            s8_last  = (i == 7);
            while (!s8_ready && t < 50) begin step(); t++; end
            if (t >= 50) begin
                n_checks++;
                $display("FAIL p8_timeout word=%0d s_ready=%b required=1", i, s8_ready);
            end
            step();
        end
        s8_valid = 1'b0;
        s8_last  = 1'b0;
        n_checks++;
        if ({v8_out, f8_first, l8_last} !== 3'b111 || d8_out !== EXP_B0 || m8_out !== 32'h41000000) begin
            $display("FAIL p8_beat flags=%b data=%h max=%h required 111/%h/41000000",
                     {v8_out, f8_first, l8_last}, d8_out, m8_out, EXP_B0);
        end else n_pass++;
        $display("p8 beat first=%b last=%b max=%h", f8_first, l8_last, m8_out);
        r8_out = 1'b1;
        step();
        r8_out = 1'b0;
        n_checks++;
        if (v8_out !== 1'b0 || s8_ready !== 1'b1) begin
            $display("FAIL p8_done out_valid=%b s_ready=%b required 0/1", v8_out, s8_ready);
        end else n_pass++;
    endtask

    task automatic test_param32();
        for (int i = 0; i < 32; i++) begin
            int t = 0;
            s32_valid = 1'b1;
            s32_data  = 32'(i + 1);
            s32_last  = (i == 31);
            while (!s32_ready && t < 50) begin step(); t++; end
            if (t >= 50) begin
                n_checks++;
                $display("FAIL p32_timeout word=%0d s_ready=%b required=1", i, s32_ready);
            end
            step();
        end
        s32_valid = 1'b0;
        s32_last  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (v32_out !== 1'b1 || f32_first !== (k == 0) || l32_last !== (k == 3)
                || d32_out[31:0] !== 32'(k * 8 + 1) || d32_out[255:224] !== 32'(k * 8 + 8)
                || m32_out !== 32'h20) begin
                $display("FAIL p32_beat%0d v=%b f=%b l=%b lane0=%h lane7=%h max=%h required 1/%b/%b/%h/%h/20",
                         k, v32_out, f32_first, l32_last, d32_out[31:0], d32_out[255:224], m32_out,
                         k == 0, k == 3, 32'(k * 8 + 1), 32'(k * 8 + 8));
            end else n_pass++;
            $display("p32 beat %0d lane0=%h", k, d32_out[31:0]);
            r32_out = 1'b1;
            step();
            r32_out = 1'b0;
        end
        n_checks++;
        if (v32_out !== 1'b0 || s32_ready !== 1'b1) begin
            $display("FAIL p32_done out_valid=%b s_ready=%b required 0/1", v32_out, s32_ready);
        end else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        s_data    = '0; s_valid   = 1'b0; s_last   = 1'b0; out_ready = 1'b0;
        s8_data   = '0; s8_valid  = 1'b0; s8_last  = 1'b0; r8_out    = 1'b0;
        s32_data  = '0; s32_valid = 1'b0; s32_last = 1'b0; r32_out   = 1'b0;
        step();
        step();
        test_reset();
        test_basic();
        test_signed_max();
        test_backpressure();
        test_framing();
        test_reset_abort();
        test_param8();
        test_param32();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
